// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: assembles n LSB-first bits into a word and
// presents it through a holding register with valid/ready and a sticky overrun flag.
module sipo_deserializer #(
    parameter int n = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 SI,
    input  logic                 shift_en,
    input  logic                 clear,
    input  logic                 ready,
    output logic [n-1:0]         P_out,
    output logic                 valid,
    output logic                 overrun,
    output logic [$clog2(n)-1:0] bit_cnt
);
    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    logic [n-1:0]  s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  p_q, p_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic [n-1:0]  shifted;
    logic          complete;
    logic          accept;

    assign shifted  = {SI, s_q[n-1:1]};
    assign complete = shift_en && (cnt_q == LAST);
    assign accept   = valid_q && ready;

    always_comb begin
        s_d     = s_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clear) begin
            s_d     = '0;
            cnt_d   = '0;
            p_d     = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (shift_en) begin
                s_d   = shifted;
                cnt_d = complete ? '0 : cnt_q + CW'(1);
            end
            if (accept)
                valid_d = 1'b0;
            // A completing word may only replace the holding register if it is free
            // or being drained on this same edge; otherwise it is dropped.
            if (complete) begin
                if (!valid_q || accept) begin
                    p_d     = shifted;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign P_out   = p_q;
    assign valid   = valid_q;
    assign overrun = ovr_q;
    assign bit_cnt = cnt_q;
endmodule
